axi_single_arbiter: RTL
=======================

AXI_SINGLE_ARBITER -- requirements
Module: axi_single_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2: number of command requesters, range 2..4.
REQ-002 SHALL have parameter IDW, default 4: AXI ID width; requester index zero-extended onto IDs.
REQ-003 SHALL have port aclk, in, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port aresetn, in, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, in, NREQ: per-requester command pending, held until accepted.
REQ-006 SHALL have port req_write, in, NREQ: 1 = write, 0 = read.
REQ-007 SHALL have ports req_addr, req_wdata: in, NREQ*32: packed address and write data, slice i = requester i.
REQ-008 SHALL have ports req_size, in, NREQ*3, and req_strb, in, NREQ*4: AXI size and write strobes.
REQ-009 SHALL have port req_ready, out, NREQ: one-cycle accept pulse.
REQ-010 SHALL have port req_done, out, NREQ: one-cycle completion pulse.
REQ-011 SHALL have ports req_rdata, out, 32, and req_resp, out, 2: result, valid while req_done is high.
REQ-012 SHALL have port id_err, out, 1: sticky flag, returned bid/rid differs from issued ID.
REQ-013 SHALL have AXI3 write-address outputs awid[IDW], awaddr[32], awlen[4], awsize[3], awburst[2], awlock[2], awcache[4], awprot[3], awvalid, and input awready.
REQ-014 SHALL have write-data outputs wid[IDW], wdata[32], wstrb[4], wlast, wvalid, and input wready.
REQ-015 SHALL have write-response inputs bid[IDW], bresp[2], bvalid, and output bready.
REQ-016 SHALL have read-address outputs arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid (widths as aw*), and input arready.
REQ-017 SHALL have read-data inputs rid[IDW], rdata[32], rresp[2], rlast, rvalid, and output rready.

Function
REQ-018 SHALL run FSM states IDLE, AW, W, B, AR, R: one outstanding single-beat transaction at a time.
REQ-019 SHALL grant in IDLE round-robin: first requester with valid set, scanning from last_grant+1 modulo NREQ.
REQ-020 SHALL in a grant cycle pulse req_ready[g], latch that slice's fields, update last_grant, and enter AW (write) or AR (read).
REQ-021 SHALL drive awvalid/arvalid from the cycle after the grant, holding all address fields stable until awready/arready is sampled high.
REQ-022 SHALL fix awlen=arlen=0, awburst=arburst=FIXED, awlock=arlock=NORMAL, awcache=arcache=0, awprot=arprot=NORMAL, and awid=arid=wid=g.
REQ-023 SHALL move AW->W on awvalid&awready, then assert wvalid with wlast=1 and hold wdata/wstrb until wready.
REQ-024 SHALL move W->B on wvalid&wready, assert bready only in B, and capture bresp on bvalid.
REQ-025 SHALL move AR->R on arvalid&arready, assert rready only in R, and capture rdata/rresp on rvalid.
REQ-026 SHALL discard any R beat with rlast=0 and stay in R until rvalid&rlast.
REQ-027 SHALL pulse req_done[g] with captured rdata/resp on the cycle after the B or R handshake and return to IDLE in that same cycle.
REQ-028 SHALL set id_err on a response handshake whose bid/rid is not g; still complete the transaction.
REQ-029 SHALL drive req_rdata to 0 for writes.
REQ-030 SHALL ignore req_valid outside IDLE; the minimum back-to-back spacing is one IDLE cycle.
REQ-031 SHALL hold all AXI outputs at 0 when not in their handshake state.

Reset
REQ-032 SHALL on aresetn low immediately drive all outputs to 0, return to IDLE, set last_grant=NREQ-1 and clear id_err.
REQ-033 SHALL abandon a transaction interrupted by reset mid-operation, with no req_done.

Structure
REQ-034 SHALL take FSM state enum and AXI burst/lock/prot encodings from shared package axi_pkg.
REQ-035 SHALL implement grant logic in sub-module rr_grant (req vector, last pointer -> one-hot grant, index).

Verification
REQ-036 SHALL cover: req0 write addr 0x100, data 0xDEADBEEF, strb 0xF; awready/wready/bvalid=1 -> awvalid 1 cycle after grant, req_done[0] with resp 0.
REQ-037 SHALL cover: req1 read 0x200, rdata 0x12345678, arready delayed 3 cycles -> araddr stable 4 cycles, req_rdata 0x12345678.
REQ-038 SHALL cover: both valid continuously for 4 transactions after reset -> grant order 0,1,0,1.
REQ-039 SHALL cover: bid=3 while serving req0 -> id_err=1 and stays 1, req_done[0] still pulses.
REQ-040 SHALL cover: aresetn low during state W -> all outputs 0 same cycle, no req_done, and the next grant goes to req0.
REQ-041 SHALL cover: read answered by a beat with rlast=0 then rdata 0xA5A5A5A5 with rlast=1 -> returns 0xA5A5A5A5.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared definitions for the single-outstanding AXI3 command arbiter:
// FSM state encoding and fixed AXI attribute encodings.
package axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B,
      ST_AR,
      ST_R
   } state_t;

   localparam logic [3:0] LEN_SINGLE  = 4'd0;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] LOCK_NORMAL = 2'b00;
   localparam logic [3:0] CACHE_NONE  = 4'b0000;
   localparam logic [2:0] PROT_NORMAL = 3'b000;

endpackage

// File: rtl/axi_single_arbiter_rr_grant.sv
// Round-robin grant: first set request scanning from last+1 modulo NREQ,
// returned as one-hot vector plus binary index.
module rr_grant #(
   parameter int NREQ = 2,
   parameter int IDXW = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] last,
   output logic [NREQ-1:0] grant,
   output logic [IDXW-1:0] idx,
   output logic            any
);

   logic [IDXW-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = IDXW'((32'(last) + k) % NREQ);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/axi_single_arbiter.sv
// Arbitrates NREQ single-beat command requesters onto one AXI3 master port,
// keeping exactly one transaction outstanding at a time.
module axi_single_arbiter
   import axi_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = 4
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_write,
   input  logic [NREQ*32-1:0] req_addr,
   input  logic [NREQ*32-1:0] req_wdata,
   input  logic [NREQ*3-1:0] req_size,
   input  logic [NREQ*4-1:0] req_strb,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   req_done,
   output logic [31:0]       req_rdata,
   output logic [1:0]        req_resp,
   output logic              id_err,
   output logic [IDW-1:0]    awid,
   output logic [31:0]       awaddr,
   output logic [3:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic [1:0]        awlock,
   output logic [3:0]        awcache,
   output logic [2:0]        awprot,
   output logic              awvalid,
   input  logic              awready,
   output logic [IDW-1:0]    wid,
   output logic [31:0]       wdata,
   output logic [3:0]        wstrb,
   output logic              wlast,
   output logic              wvalid,
   input  logic              wready,
   input  logic [IDW-1:0]    bid,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   output logic [IDW-1:0]    arid,
   output logic [31:0]       araddr,
   output logic [3:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic [1:0]        arlock,
   output logic [3:0]        arcache,
   output logic [2:0]        arprot,
   output logic              arvalid,
   input  logic              arready,
   input  logic [IDW-1:0]    rid,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready
);

   localparam int IDXW = $clog2(NREQ);

   state_t          state, state_nx;
   logic [IDXW-1:0] last_grant, cur_idx, gnt_idx;
   logic [NREQ-1:0] gnt, done_vec;
   logic            gnt_any, grant_fire;
   logic [31:0]     cur_addr, cur_wdata, sel_addr, sel_wdata;
   logic [2:0]      cur_size, sel_size;
   logic [3:0]      cur_strb, sel_strb;
   logic [IDW-1:0]  cur_id;

   rr_grant #(
      .NREQ(NREQ),
      .IDXW(IDXW)
   ) u_grant (
      .req  (req_valid),
      .last (last_grant),
      .grant(gnt),
      .idx  (gnt_idx),
      .any  (gnt_any)
   );

   assign grant_fire = (state == ST_IDLE) && gnt_any;
   assign cur_id     = IDW'(cur_idx);
   assign done_vec   = {{(NREQ-1){1'b0}}, 1'b1} << cur_idx;
   assign sel_addr   = req_addr[32*int'(gnt_idx) +: 32];
   assign sel_wdata  = req_wdata[32*int'(gnt_idx) +: 32];
   assign sel_size   = req_size[3*int'(gnt_idx) +: 3];
   assign sel_strb   = req_strb[4*int'(gnt_idx) +: 4];

   // Gated by aresetn so the accept pulse drops the instant reset asserts.
   assign req_ready  = (grant_fire && aresetn) ? gnt : '0;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= ST_IDLE;
         last_grant <= IDXW'(NREQ-1);
         cur_idx    <= '0;
         cur_addr   <= '0;
         cur_wdata  <= '0;
         cur_size   <= '0;
         cur_strb   <= '0;
         req_done   <= '0;
         req_rdata  <= '0;
         req_resp   <= '0;
         id_err     <= 1'b0;
      end else begin
         state    <= state_nx;
         req_done <= '0;
         if (grant_fire) begin
            last_grant <= gnt_idx;
            cur_idx    <= gnt_idx;
            cur_addr   <= sel_addr;
            cur_wdata  <= sel_wdata;
            cur_size   <= sel_size;
            cur_strb   <= sel_strb;
         end
         if (state == ST_B && bvalid) begin
            req_done  <= done_vec;
            req_rdata <= '0;
            req_resp  <= bresp;
            if (bid != cur_id) id_err <= 1'b1;
         end
         if (state == ST_R && rvalid) begin
            if (rid != cur_id) id_err <= 1'b1;
            if (rlast) begin
               req_done  <= done_vec;
               req_rdata <= rdata;
               req_resp  <= rresp;
            end
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (gnt_any) state_nx = req_write[gnt_idx] ? ST_AW : ST_AR;
         ST_AW:   if (awready) state_nx = ST_W;
         ST_W:    if (wready) state_nx = ST_B;
         ST_B:    if (bvalid) state_nx = ST_IDLE;
         ST_AR:   if (arready) state_nx = ST_R;
         ST_R:    if (rvalid && rlast) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      awid    = '0;
      awaddr  = '0;
      awlen   = '0;
      awsize  = '0;
      awburst = '0;
      awlock  = '0;
      awcache = '0;
      awprot  = '0;
      awvalid = 1'b0;
      wid     = '0;
      wdata   = '0;
      wstrb   = '0;
      wlast   = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b0;
      arid    = '0;
      araddr  = '0;
      arlen   = '0;
      arsize  = '0;
      arburst = '0;
      arlock  = '0;
      arcache = '0;
      arprot  = '0;
      arvalid = 1'b0;
      rready  = 1'b0;
      case (state)
         ST_AW: begin
            awvalid = 1'b1;
            awid    = cur_id;
            awaddr  = cur_addr;
            awlen   = LEN_SINGLE;
            awsize  = cur_size;
            awburst = BURST_FIXED;
            awlock  = LOCK_NORMAL;
            awcache = CACHE_NONE;
            awprot  = PROT_NORMAL;
         end
         ST_W: begin
            wvalid = 1'b1;
            wid    = cur_id;
            wdata  = cur_wdata;
            wstrb  = cur_strb;
            wlast  = 1'b1;
         end
         ST_B: bready = 1'b1;
         ST_AR: begin
            arvalid = 1'b1;
            arid    = cur_id;
            araddr  = cur_addr;
            arlen   = LEN_SINGLE;
            arsize  = cur_size;
            arburst = BURST_FIXED;
            arlock  = LOCK_NORMAL;
            arcache = CACHE_NONE;
            arprot  = PROT_NORMAL;
         end
         ST_R: rready = 1'b1;
         default: ;
      endcase
   end

endmodule
